psec5_readout_sequencer: RTL and testbench



---
 rtl/psec5_pkg.sv | 22 ++
 rtl/psec5_rr_arbiter.sv | 44 ++++
 rtl/psec5_readout_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_psec5_readout_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psec5_pkg.sv
// Shared types and constants for the PSEC5 readout sequencer.
package psec5_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        RO_IDLE  = 3'd0,
        RO_ARB   = 3'd1,
        RO_LOAD  = 3'd2,
        RO_SHIFT = 3'd3,
        RO_ACK   = 3'd4,
        RO_FIN   = 3'd5
    } ro_state_t;

    // Width of one channel counter snapshot {6'b0, CE, CD, CC, CB, CA}
    localparam int PSEC5_SNAP_W = 56;

    // Channel-ID field width: at least one bit even for a single channel
    function automatic int chid_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/psec5_rr_arbiter.sv
// Round-robin first-set search: returns the first pending channel at or
// above rr_ptr, wrapping modulo NUM_CH. Purely combinational.
module psec5_rr_arbiter
    import psec5_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CHID_W = 2
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CHID_W-1:0] rr_ptr,
    output logic [CHID_W-1:0] sel,
    output logic              any
);

    logic [NUM_CH-1:0] rot_s;
    logic [CHID_W-1:0] off_s;

    // (base + off) mod NUM_CH as a channel index
    function automatic logic [CHID_W-1:0] wrap_add(input logic [CHID_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NUM_CH;
        return CHID_W'(sum);
    endfunction

    // Rotate pending so that bit 0 corresponds to the channel at rr_ptr
    always_comb begin
        rot_s = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            rot_s[k] = pending[wrap_add(rr_ptr, k)];
        end
    end

    // Lowest set bit of the rotated vector (scan high to low, last hit wins)
    always_comb begin
        off_s = {CHID_W{1'b0}};
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? CHID_W'(k) : off_s;
        end
    end

    assign sel = wrap_add(rr_ptr, int'(off_s));
    assign any = |pending;

endmodule

// File: rtl/psec5_readout_sequencer.sv
// PSEC5 readout sequencer: freezes the set of valid channels on a readout
// request, grants them round-robin and shifts {chid, snapshot} out MSB-first,
// acknowledging each channel once its frame is complete.
// Optional build macro PSEC5_RO_PARITY_EN appends an even-parity bit to
// every frame.
module psec5_readout_sequencer
    import psec5_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = PSEC5_SNAP_W,
    parameter int CHID_W = ($clog2(NUM_CH) < 1 ? 1 : $clog2(NUM_CH))
) (
    input  logic                     SPI_CLK,
    input  logic                     RSTB,
    input  logic                     READOUT_REQ,
    input  logic                     ABORT,
    input  logic [NUM_CH-1:0]        CH_VALID,
    input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
    output logic [NUM_CH-1:0]        CH_ACK,
    output logic                     SDO,
    output logic                     SDO_FRAME,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam int FRAME_LEN = CHID_W + DATA_W;
`ifdef PSEC5_RO_PARITY_EN
    localparam int SR_W = FRAME_LEN + 1;
`else
    localparam int SR_W = FRAME_LEN;
`endif
    localparam int                CNT_W     = $clog2(SR_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SR_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_CH-1:0] ACK_ONE   = NUM_CH'(1);
    localparam logic [NUM_CH-1:0] CH_NONE   = {NUM_CH{1'b0}};
    localparam logic [CHID_W-1:0] CH_LAST   = CHID_W'(NUM_CH - 1);
    localparam logic [CHID_W-1:0] CH_ZERO   = {CHID_W{1'b0}};
    localparam logic [CHID_W-1:0] CH_ONE    = CHID_W'(1);

    // Even parity over a complete frame (chid + data)
    function automatic logic even_parity(input logic [FRAME_LEN-1:0] word);
        return ^word;
    endfunction

    // Next channel index after c, wrapping to 0
    function automatic logic [CHID_W-1:0] next_ch(input logic [CHID_W-1:0] c);
        return (c == CH_LAST) ? CH_ZERO : (c + CH_ONE);
    endfunction

    ro_state_t          state_r;
    ro_state_t          state_next_s;
    ro_state_t          norm_next_s;
    logic               abort_s;

    logic [NUM_CH-1:0]  pending_r;
    logic [CHID_W-1:0]  rr_ptr_r;
    logic [CHID_W-1:0]  sel_r;
    logic [CHID_W-1:0]  arb_sel_s;
    logic               arb_any_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [SR_W-1:0]    shift_r;

    logic [DATA_W-1:0]    data_sel_s;
    logic [FRAME_LEN-1:0] frame_word_s;
    logic [SR_W-1:0]      load_word_s;

    logic               sdo_r;
    logic               frame_r;
    logic [NUM_CH-1:0]  ack_r;
    logic               busy_r;
    logic               done_r;

    psec5_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CHID_W (CHID_W)
    ) u_arb (
        .pending (pending_r),
        .rr_ptr  (rr_ptr_r),
        .sel     (arb_sel_s),
        .any     (arb_any_s)
    );

    // Pick the granted channel's snapshot out of the flat data bus
    always_comb begin
        data_sel_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            data_sel_s = (sel_r == CHID_W'(i)) ? CH_DATA[i*DATA_W +: DATA_W] : data_sel_s;
        end
    end

    // Assemble the word loaded into the shift register
    always_comb begin
        frame_word_s = {sel_r, data_sel_s};
`ifdef PSEC5_RO_PARITY_EN
        load_word_s  = {frame_word_s, even_parity(frame_word_s)};
`else
        load_word_s  = frame_word_s;
`endif
    end

    // Next-state logic; ABORT overrides every transition outside IDLE
    always_comb begin
        abort_s     = ABORT && (state_r != RO_IDLE);
        norm_next_s = state_r;
        case (state_r)
            RO_IDLE:  norm_next_s = READOUT_REQ ? RO_ARB : RO_IDLE;
            RO_ARB:   norm_next_s = arb_any_s ? RO_LOAD : RO_FIN;
            RO_LOAD:  norm_next_s = RO_SHIFT;
            RO_SHIFT: norm_next_s = (cnt_r == CNT_ZERO) ? RO_ACK : RO_SHIFT;
            RO_ACK:   norm_next_s = RO_ARB;
            RO_FIN:   norm_next_s = RO_IDLE;
            default:  norm_next_s = RO_IDLE;
        endcase
        state_next_s = abort_s ? RO_IDLE : norm_next_s;
    end

    // State register
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_r <= RO_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs, driven by the state being left
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            pending_r <= CH_NONE;
            rr_ptr_r  <= CH_ZERO;
            sel_r     <= CH_ZERO;
            cnt_r     <= CNT_ZERO;
            shift_r   <= {SR_W{1'b0}};
            sdo_r     <= 1'b0;
            frame_r   <= 1'b0;
            ack_r     <= CH_NONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (abort_s) begin
            // Drop the pass; rr_ptr keeps the last completed grant
            pending_r <= CH_NONE;
            cnt_r     <= CNT_ZERO;
            shift_r   <= {SR_W{1'b0}};
            sdo_r     <= 1'b0;
            frame_r   <= 1'b0;
            ack_r     <= CH_NONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            sdo_r   <= 1'b0;
            frame_r <= 1'b0;
            ack_r   <= CH_NONE;
            done_r  <= 1'b0;
            busy_r  <= (state_next_s != RO_IDLE);
            case (state_r)
                RO_IDLE: begin
                    // Freeze the channel set for this pass
                    if (READOUT_REQ) begin
                        pending_r <= CH_VALID;
                    end
                end
                RO_ARB: begin
                    sel_r <= arb_sel_s;
                end
                RO_LOAD: begin
                    shift_r <= load_word_s;
                    cnt_r   <= CNT_LAST;
                end
                RO_SHIFT: begin
                    sdo_r   <= shift_r[SR_W-1];
                    frame_r <= 1'b1;
                    shift_r <= {shift_r[SR_W-2:0], 1'b0};
                    cnt_r   <= (cnt_r == CNT_ZERO) ? CNT_ZERO : (cnt_r - CNT_ONE);
                end
                RO_ACK: begin
                    ack_r            <= ACK_ONE << sel_r;
                    pending_r[sel_r] <= 1'b0;
                    rr_ptr_r         <= next_ch(sel_r);
                end
                RO_FIN: begin
                    done_r <= 1'b1;
                end
                default: begin
                    pending_r <= CH_NONE;
                end
            endcase
        end
    end

    assign CH_ACK    = ack_r;
    assign SDO       = sdo_r;
    assign SDO_FRAME = frame_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;

endmodule

// File: tb/tb_psec5_readout_sequencer.sv
// Self-checking bench for psec5_readout_sequencer (NUM_CH=4). A pass-level
// model turns each accepted request into the expected per-cycle output
// stream; directed passes pin frame content, ordering and timing literally,
// followed by a randomized phase.
module tb_psec5_readout_sequencer;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 56;
    localparam int FL_BASE = 58;
`ifdef PSEC5_RO_PARITY_EN
    localparam int FL_TB = FL_BASE + 1;
`else
    localparam int FL_TB = FL_BASE;
`endif

    logic                     SPI_CLK = 1'b0;
    logic                     RSTB = 1'b0;
    logic                     READOUT_REQ = 1'b0;
    logic                     ABORT = 1'b0;
    logic [NUM_CH-1:0]        CH_VALID = 4'b0;
    logic [NUM_CH*DATA_W-1:0] CH_DATA = '0;
    logic [NUM_CH-1:0]        CH_ACK;
    logic                     SDO, SDO_FRAME, BUSY, DONE;

    psec5_readout_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .SPI_CLK(SPI_CLK), .RSTB(RSTB), .READOUT_REQ(READOUT_REQ), .ABORT(ABORT),
        .CH_VALID(CH_VALID), .CH_DATA(CH_DATA), .CH_ACK(CH_ACK),
        .SDO(SDO), .SDO_FRAME(SDO_FRAME), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 SPI_CLK = ~SPI_CLK;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       busy;
        logic       frame;
        logic       sdo;
        logic [3:0] ack;
        logic       done;
        logic       upd;
        logic [1:0] ptr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '0;
    bit   m_busy = 1'b0;
    int   m_rr = 0;

    function automatic exp_t mk(input logic busy, input logic frame, input logic sdo,
                                input logic [3:0] ack, input logic done,
                                input logic upd, input logic [1:0] ptr);
        exp_t e;
        e.busy = busy; e.frame = frame; e.sdo = sdo; e.ack = ack;
        e.done = done; e.upd = upd; e.ptr = ptr;
        return e;
    endfunction

    // Expected outputs after the request edge and every following edge
    task automatic build_pass(input logic [3:0] valid, input logic [NUM_CH*DATA_W-1:0] data);
        logic [3:0]         pend;
        int                 ptr;
        int                 c;
        logic [1:0]         cid;
        logic [FL_BASE-1:0] fw;
        pend = valid;
        ptr  = m_rr;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 2'b0));
        while (pend != 4'b0) begin
            c = -1;
            for (int k = 0; k < NUM_CH; k++)
                if (c < 0 && pend[(ptr + k) % NUM_CH]) c = (ptr + k) % NUM_CH;
            cid = 2'(c);
            fw  = {cid, data[c*DATA_W +: DATA_W]};
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 2'b0));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 2'b0));
            for (int b = FL_BASE - 1; b >= 0; b--)
                exp_q.push_back(mk(1'b1, 1'b1, fw[b], 4'b0, 1'b0, 1'b0, 2'b0));
`ifdef PSEC5_RO_PARITY_EN
            exp_q.push_back(mk(1'b1, 1'b1, ^fw, 4'b0, 1'b0, 1'b0, 2'b0));
`endif
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'(1 << c), 1'b0, 1'b1, 2'((c + 1) % NUM_CH)));
            pend[c] = 1'b0;
            ptr     = (c + 1) % NUM_CH;
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 2'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 2'b0));
    endtask

    // Model step on every edge, then compare the DUT just after it
    always @(posedge SPI_CLK) begin
        if (!RSTB) begin
            exp_q.delete();
            cur  = '0;
            m_rr = 0;
        end else if (m_busy && ABORT) begin
            exp_q.delete();
            cur = '0;
        end else if (!m_busy && READOUT_REQ) begin
            build_pass(CH_VALID, CH_DATA);
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = '0;
        end
        if (cur.upd) m_rr = int'(cur.ptr);
        m_busy = cur.busy;
        #1;
        check("cycle_outputs{busy,frame,sdo,ack,done}",
              64'({BUSY, SDO_FRAME, SDO, CH_ACK, DONE}),
              64'({cur.busy, cur.frame, cur.sdo, cur.ack, cur.done}));
    end

    // ---------------- directed-pass capture ----------------
    logic [63:0] bb [4];
    int          bl [4];
    int          nb;
    logic [3:0]  acks [8];
    int          na;
    int          done_idx;
    logic [7:0]  busy_hist;
    logic [63:0] cur_bits;
    int          cur_len;

    task automatic sample(input int idx);
        if (SDO_FRAME) begin
            cur_bits = {cur_bits[62:0], SDO};
            cur_len++;
        end else if (cur_len > 0) begin
            if (nb < 4) begin bb[nb] = cur_bits; bl[nb] = cur_len; end
            nb++;
            cur_bits = '0;
            cur_len  = 0;
        end
        if (CH_ACK != 4'b0 && na < 8) begin acks[na] = CH_ACK; na++; end
        if (DONE && done_idx < 0) done_idx = idx;
        if (idx < 8) busy_hist[idx] = BUSY;
    endtask

    task automatic run_pass(input logic [3:0] v, input int abort_at, input int chg_at, input int chg_ch);
        bit fin;
        fin = 1'b0; nb = 0; na = 0; done_idx = -1; busy_hist = '0; cur_bits = '0; cur_len = 0;
        @(negedge SPI_CLK);
        READOUT_REQ = 1'b1; CH_VALID = v;
        @(posedge SPI_CLK); #2;
        sample(0);
        for (int i = 1; i < 400 && !fin; i++) begin
            @(negedge SPI_CLK);
            READOUT_REQ = 1'b0;
            ABORT = (i == abort_at);
            if (i == chg_at) CH_DATA[chg_ch*DATA_W +: DATA_W] = ~CH_DATA[chg_ch*DATA_W +: DATA_W];
            @(posedge SPI_CLK); #2;
            sample(i);
            if (i == abort_at) begin
                check("abort_next_cycle_quiet", 64'({BUSY, SDO_FRAME, CH_ACK, DONE}), 64'd0);
                fin = 1'b1;
            end
            if (DONE) fin = 1'b1;
        end
        check("pass_end_reached", 64'(fin), 64'd1);
        @(negedge SPI_CLK);
        ABORT = 1'b0;
    endtask

    localparam logic [55:0] D1 = 56'hA5C30FF05A3C96;
    localparam logic [55:0] D3 = 56'h0123456789ABCD;
    localparam logic [55:0] D7 = 56'hF0E1D2C3B4A596;

    logic [63:0] fexp;

    initial begin
        // reset
        repeat (2) @(posedge SPI_CLK);
        #2;
        check("reset_outputs", 64'({BUSY, SDO_FRAME, SDO, CH_ACK, DONE}), 64'd0);
        @(negedge SPI_CLK);
        RSTB = 1'b1;
        repeat (2) @(negedge SPI_CLK);

        // two channels, ch1 then ch3
        CH_DATA[1*DATA_W +: DATA_W] = D1;
        CH_DATA[3*DATA_W +: DATA_W] = D3;
        run_pass(4'b1010, -1, -1, 0);
        check("t2_burst_count", 64'(nb), 64'd2);
        check("t2_burst_len0", 64'(bl[0]), 64'(FL_TB));
        check("t2_burst_len1", 64'(bl[1]), 64'(FL_TB));
        fexp = {6'b0, 2'b01, D1};
`ifdef PSEC5_RO_PARITY_EN
        fexp = {fexp[62:0], ^fexp};
`endif
        check("t2_frame_ch1", bb[0], fexp);
        fexp = {6'b0, 2'b11, D3};
`ifdef PSEC5_RO_PARITY_EN
        fexp = {fexp[62:0], ^fexp};
`endif
        check("t2_frame_ch3", bb[1], fexp);
        check("t2_ack_count", 64'(na), 64'd2);
        check("t2_ack0", 64'(acks[0]), 64'(4'b0010));
        check("t2_ack1", 64'(acks[1]), 64'(4'b1000));
        check("t2_done_index", 64'(done_idx), 64'(2 * FL_TB + 8));

        // round robin across passes
        run_pass(4'b1111, -1, -1, 0);
        check("rr_all_count", 64'(na), 64'd4);
        check("rr_all_0", 64'(acks[0]), 64'(4'b0001));
        check("rr_all_1", 64'(acks[1]), 64'(4'b0010));
        check("rr_all_2", 64'(acks[2]), 64'(4'b0100));
        check("rr_all_3", 64'(acks[3]), 64'(4'b1000));
        run_pass(4'b0001, -1, -1, 0);
        check("rr_ch0_only", 64'(acks[0]), 64'(4'b0001));
        run_pass(4'b1001, -1, -1, 0);
        check("rr_wrap_first", 64'(acks[0]), 64'(4'b1000));
        check("rr_wrap_second", 64'(acks[1]), 64'(4'b0001));

        // empty pass
        run_pass(4'b0000, -1, -1, 0);
        check("empty_no_frame", 64'(nb), 64'd0);
        check("empty_done_index", 64'(done_idx), 64'd2);
        check("empty_busy_hist", 64'(busy_hist[2:0]), 64'(3'b011));

        // abort on the 20th shift cycle, then rr_ptr unchanged (still 1)
        run_pass(4'b0100, 22, -1, 0);
        check("abort_no_ack", 64'(na), 64'd0);
        repeat (2) @(negedge SPI_CLK);
        run_pass(4'b0101, -1, -1, 0);
        check("post_abort_first", 64'(acks[0]), 64'(4'b0100));
        check("post_abort_second", 64'(acks[1]), 64'(4'b0001));

        // async reset mid-frame
        @(negedge SPI_CLK);
        READOUT_REQ = 1'b1; CH_VALID = 4'b0010;
        @(negedge SPI_CLK);
        READOUT_REQ = 1'b0;
        repeat (10) @(negedge SPI_CLK);
        check("rstb_midframe_active", 64'(SDO_FRAME), 64'd1);
        #2 RSTB = 1'b0;
        #1;
        check("rstb_async_outputs", 64'({BUSY, SDO_FRAME, SDO, CH_ACK, DONE}), 64'd0);
        @(posedge SPI_CLK);
        @(negedge SPI_CLK);
        RSTB = 1'b1;
        repeat (2) @(negedge SPI_CLK);

        // data changed during SHIFT: frame keeps LOAD-time value
        CH_DATA[1*DATA_W +: DATA_W] = D7;
        run_pass(4'b0010, -1, 10, 1);
        fexp = {6'b0, 2'b01, D7};
`ifdef PSEC5_RO_PARITY_EN
        fexp = {fexp[62:0], ^fexp};
`endif
        check("data_change_frame", bb[0], fexp);

        // frame length and final bit for data = 1 on ch0
        CH_DATA[0 +: DATA_W] = 56'h00000000000001;
        run_pass(4'b0001, -1, -1, 0);
        check("len_frame_bits", 64'(bl[0]), 64'(FL_TB));
        check("len_last_bit", 64'(bb[0][0]), 64'd1);
`ifdef PSEC5_RO_PARITY_EN
        check("len_frame_value", bb[0], 64'd3);
`else
        check("len_frame_value", bb[0], 64'd1);
`endif

        // randomized phase
        for (int n = 0; n < 6000; n++) begin
            @(negedge SPI_CLK);
            RSTB        = ($urandom_range(0, 1499) != 0);
            READOUT_REQ = ($urandom_range(0, 3) == 0);
            ABORT       = ($urandom_range(0, 249) == 0);
            CH_VALID    = 4'($urandom);
            if (!m_busy) begin
                for (int c = 0; c < NUM_CH; c++)
                    CH_DATA[c*DATA_W +: DATA_W] = {24'($urandom), 32'($urandom)};
            end
        end
        @(negedge SPI_CLK);
        RSTB = 1'b1; READOUT_REQ = 1'b0; ABORT = 1'b0;
        repeat (3) @(negedge SPI_CLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
